// File: rtl/neuron_sweep_sequencer_if.sv
// ==== neuron_sweep_sequencer_if : operand/result bus to the Izhikevich pipeline -- rev 1.0 ====
`default_nettype none

interface neuron_sweep_sequencer_if;
  logic [16:0] p_a;
  logic [16:0] p_b;
  logic [16:0] p_c;
  logic [16:0] p_d;
  logic [16:0] p_v;
  logic [16:0] p_u;
  logic [16:0] p_i;
  logic        p_valid;
  logic [16:0] p_v_prime;
  logic [16:0] p_u_prime;
  logic        p_fired;

  modport master (
    output p_a, p_b, p_c, p_d, p_v, p_u, p_i, p_valid,
    input  p_v_prime, p_u_prime, p_fired
  );

  modport slave (
    input  p_a, p_b, p_c, p_d, p_v, p_u, p_i, p_valid,
    output p_v_prime, p_u_prime, p_fired
  );
endinterface

`default_nettype wire

// File: rtl/neuron_sweep_sequencer.sv
// ==== neuron_sweep_sequencer : issues every neuron once per sweep and writes back v'/u' -- rev 1.0 ====
`default_nettype none

module neuron_sweep_sequencer #(
  parameter int N_NEURONS = 16,
  parameter int ADDR_W    = 4,
  parameter int PIPE_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [2:0]            cfg_sel,
  input  logic [16:0]           cfg_wdata,
  output logic [16:0]           cfg_rdata,
  output logic [ADDR_W-1:0]     i_addr,
  input  logic [16:0]           i_data,
  neuron_sweep_sequencer_if.master pipe,
  output logic                  spike_valid,
  output logic [ADDR_W-1:0]     spike_addr,
  output logic [ADDR_W:0]       spike_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_NEURONS - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(N_NEURONS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              last;
  logic [ADDR_W-1:0] p_idx;
  logic              pvalid;
  logic [16:0]       pa, pb, pc, pd, pv, pu, pi;

  logic [16:0] mem_a [N_NEURONS];
  logic [16:0] mem_b [N_NEURONS];
  logic [16:0] mem_c [N_NEURONS];
  logic [16:0] mem_d [N_NEURONS];
  logic [16:0] mem_v [N_NEURONS];
  logic [16:0] mem_u [N_NEURONS];

  logic [PIPE_LAT-1:0] wb_valid;
  logic [ADDR_W-1:0]   wb_idx [PIPE_LAT];
  logic [PIPE_LAT:0]   chain;
  logic                wb_fire;
  logic [ADDR_W-1:0]   wb_addr;
  logic                issue;
  logic                spike_hit;

  // The tracking chain starts at the presented operands, so its tail lines up with the pipeline output.
  assign chain     = {wb_valid, pvalid};
  assign wb_fire   = wb_valid[PIPE_LAT-1];
  assign wb_addr   = wb_idx[PIPE_LAT-1];
  assign spike_hit = wb_fire && pipe.p_fired;
  assign issue     = ((state == IDLE) && start) || ((state == ISSUE) && !last);
  assign i_addr    = idx;

  assign pipe.p_a     = pa;
  assign pipe.p_b     = pb;
  assign pipe.p_c     = pc;
  assign pipe.p_d     = pd;
  assign pipe.p_v     = pv;
  assign pipe.p_u     = pu;
  assign pipe.p_i     = pi;
  assign pipe.p_valid = pvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      last        <= 1'b0;
      p_idx       <= '0;
      pvalid      <= 1'b0;
      pa          <= '0;
      pb          <= '0;
      pc          <= '0;
      pd          <= '0;
      pv          <= '0;
      pu          <= '0;
      pi          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_addr  <= '0;
      spike_count <= '0;
      wb_valid    <= '0;
      for (int j = 0; j < PIPE_LAT; j++) begin
        wb_idx[j] <= '0;
      end
    end else begin
      done        <= 1'b0;
      spike_valid <= spike_hit;
      wb_valid    <= chain[PIPE_LAT-1:0];
      wb_idx[0]   <= p_idx;
      for (int j = 1; j < PIPE_LAT; j++) begin
        wb_idx[j] <= wb_idx[j-1];
      end

      if (spike_hit) begin
        spike_addr <= wb_addr;
        if (spike_count != COUNT_MAX) begin
          spike_count <= spike_count + 1'b1;
        end
      end

      // idx is 0 in IDLE, so the start edge and ISSUE edges share one load path.
      if (issue) begin
        pa     <= mem_a[idx];
        pb     <= mem_b[idx];
        pc     <= mem_c[idx];
        pd     <= mem_d[idx];
        pv     <= mem_v[idx];
        pu     <= mem_u[idx];
        pi     <= i_data;
        p_idx  <= idx;
        pvalid <= 1'b1;
        idx    <= idx + 1'b1;
        last   <= (idx == LAST_IDX);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            spike_count <= '0;
          end
        end
        ISSUE: begin
          if (last) begin
            pvalid <= 1'b0;
            last   <= 1'b0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once the only live entry is the one retiring at this edge.
          if (chain[PIPE_LAT-1:0] == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        mem_a[n] <= '0;
        mem_b[n] <= '0;
        mem_c[n] <= '0;
        mem_d[n] <= '0;
        mem_v[n] <= '0;
        mem_u[n] <= '0;
      end
    end else begin
      if ((state == IDLE) && cfg_we) begin
        case (cfg_sel)
          3'd0:    mem_a[cfg_addr] <= cfg_wdata;
          3'd1:    mem_b[cfg_addr] <= cfg_wdata;
          3'd2:    mem_c[cfg_addr] <= cfg_wdata;
          3'd3:    mem_d[cfg_addr] <= cfg_wdata;
          3'd4:    mem_v[cfg_addr] <= cfg_wdata;
          3'd5:    mem_u[cfg_addr] <= cfg_wdata;
          default: ;
        endcase
      end
      if (wb_fire) begin
        mem_v[wb_addr] <= pipe.p_v_prime;
        mem_u[wb_addr] <= pipe.p_u_prime;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_sel)
      3'd0:    cfg_rdata = mem_a[cfg_addr];
      3'd1:    cfg_rdata = mem_b[cfg_addr];
      3'd2:    cfg_rdata = mem_c[cfg_addr];
      3'd3:    cfg_rdata = mem_d[cfg_addr];
      3'd4:    cfg_rdata = mem_v[cfg_addr];
      3'd5:    cfg_rdata = mem_u[cfg_addr];
      default: cfg_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_sweep_sequencer.sv
// ==== tb_neuron_sweep_sequencer : directed + randomized sweeps against a stub pipeline and field model -- rev 1.0 ====
`default_nettype none

module tb_neuron_sweep_sequencer;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [2:0]    cfg_sel = '0;
  logic [16:0]   cfg_wdata = '0;
  logic [16:0]   cfg_rdata;
  logic [AW-1:0] i_addr;
  logic [16:0]   i_data;
  logic          spike_valid;
  logic [AW-1:0] spike_addr;
  logic [AW:0]   spike_count;

  int compared = 0;
  int mismatched = 0;

  logic [16:0] model [6][N];
  logic [16:0] cur [N];

  neuron_sweep_sequencer_if pif ();

  neuron_sweep_sequencer #(.N_NEURONS(N), .ADDR_W(AW), .PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .i_addr(i_addr), .i_data(i_data), .pipe(pif),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  assign i_data = cur[i_addr];

  // Stub pipeline: four-cycle delay, v+0x100, u+1, fires when v >= 0x1E00.
  logic [16:0] sv [L];
  logic [16:0] su [L];
  logic        sf [L];
  always_ff @(posedge clk) begin
    sv[0] <= pif.p_v + 17'h00100;
    su[0] <= pif.p_u + 17'h00001;
    sf[0] <= (pif.p_v >= 17'h01E00);
    for (int j = 1; j < L; j++) begin
      sv[j] <= sv[j-1];
      su[j] <= su[j-1];
      sf[j] <= sf[j-1];
    end
  end
  assign pif.p_v_prime = sv[L-1];
  assign pif.p_u_prime = su[L-1];
  assign pif.p_fired   = sf[L-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int n, input int s, input logic [16:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(n); cfg_sel = 3'(s); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (s < 6) model[s][n] = d;
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < N; n++) begin
      for (int s = 0; s < 8; s++) begin
        cfg_addr = AW'(n); cfg_sel = 3'(s);
        #1;
        check($sformatf("%s rd n%0d s%0d", tag, n, s), 32'(cfg_rdata),
              (s < 6) ? 32'(model[s][n]) : 32'd0);
      end
    end
  endtask

  task automatic randomize_cfg();
    for (int n = 0; n < N; n++) begin
      for (int s = 0; s < 6; s++) begin
        cfg_write(n, s, (s == 4) ? 17'($urandom_range(0, 17'h3FFF)) : 17'($urandom));
      end
    end
  endtask

  // One sweep: start sampled at E0, checks in cycles 1..9, leaves the bench at the done-cycle negedge.
  task automatic sweep(input string tag, input int poke, input bit b2b);
    logic [16:0] pobs [7];
    bit          fired [N];
    int          nfired;
    nfired = 0;
    for (int k = 0; k < N; k++) begin
      fired[k] = (model[4][k] >= 17'h01E00);
      if (fired[k]) nfired++;
      cur[k] = 17'($urandom);
    end
    if (!b2b) @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= N + L + 1; c++) begin
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= N + L));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == N + L + 1));
      check($sformatf("%s p_valid c%0d", tag, c), 32'(pif.p_valid), 32'(c <= N));
      pobs = '{pif.p_a, pif.p_b, pif.p_c, pif.p_d, pif.p_v, pif.p_u, pif.p_i};
      for (int s = 0; s < 7; s++) begin
        check($sformatf("%s p_op%0d c%0d", tag, s, c), 32'(pobs[s]),
              (s == 6) ? 32'(cur[(c <= N) ? c - 1 : N - 1])
                       : 32'(model[s][(c <= N) ? c - 1 : N - 1]));
      end
      if (c > L + 1 && fired[c - L - 2]) begin
        check($sformatf("%s spike_valid c%0d", tag, c), 32'(spike_valid), 32'd1);
        check($sformatf("%s spike_addr c%0d", tag, c), 32'(spike_addr), 32'(c - L - 2));
      end else begin
        check($sformatf("%s spike_valid c%0d", tag, c), 32'(spike_valid), 32'd0);
      end
      if (c == 1) check($sformatf("%s count clear", tag), 32'(spike_count), 32'd0);
      if (c == N + L + 1) check($sformatf("%s count final", tag), 32'(spike_count), 32'(nfired));
      if (c == poke) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = AW'(1); cfg_sel = 3'd4; cfg_wdata = 17'h0AAAA;
      end
    end
    for (int k = 0; k < N; k++) begin
      model[4][k] = model[4][k] + 17'h00100;
      model[5][k] = model[5][k] + 17'h00001;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " p_valid"}, 32'(pif.p_valid), 32'd0);
    check({tag, " p_a"}, 32'(pif.p_a), 32'd0);
    check({tag, " p_v"}, 32'(pif.p_v), 32'd0);
    check({tag, " p_i"}, 32'(pif.p_i), 32'd0);
    check({tag, " spike_valid"}, 32'(spike_valid), 32'd0);
    check({tag, " spike_addr"}, 32'(spike_addr), 32'd0);
    check({tag, " spike_count"}, 32'(spike_count), 32'd0);
    check({tag, " i_addr"}, 32'(i_addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < 6; s++) for (int n = 0; n < N; n++) model[s][n] = '0;
    for (int n = 0; n < N; n++) cur[n] = '0;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    cfg_write(2, 4, 17'h01E00);
    cfg_write(3, 5, 17'h00005);
    cfg_write(1, 6, 17'h1FFFF);
    check_all("cfg");

    sweep("sweep1", 0, 1'b0);
    check_all("after1");
    sweep("sweep2", 0, 1'b0);
    sweep("ignored", 3, 1'b0);
    check_all("after_ignored");

    sweep("b2b_a", 0, 1'b0);
    sweep("b2b_b", 0, 1'b1);
    check_all("after_b2b");

    randomize_cfg();
    sweep("rand1", 0, 1'b0);
    sweep("rand2", 0, 1'b0);
    check_all("after_rand");

    // Reset in cycle 6 of a sweep.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    for (int s = 0; s < 6; s++) for (int n = 0; n < N; n++) model[s][n] = '0;
    check_all("midreset");
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("post_reset done c%0d", c), 32'(done), 32'd0);
      check($sformatf("post_reset busy c%0d", c), 32'(busy), 32'd0);
    end

    randomize_cfg();
    sweep("rand3", 0, 1'b0);
    check_all("after_rand3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
